pcs_pattern_gen_chk: RTL and testbench
======================================

// Module: pcs_pattern_gen_chk
// PURPOSE
//  Synthesizable fixed-pattern generator and checker for 10GBASE-R PCS line-loopback testing.
//  Generator drives a programmable table of PATTERN_COUNT blocks (data+header) onto the SERDES TX side in a cycle.
//  Checker hunts for the loopback latency (0..MAX_LATENCY cycles), locks, and counts block and bit errors.
//  Sits between the PCS SERDES interface and the loopback path; it replaces bench-side delay lines and compare logic.
// PARAMETERS
//  DATA_WIDTH     64  block payload width (multiple of 8)
//  HDR_WIDTH      2   sync header width
//  PATTERN_COUNT  6   pattern table entries (>=2)
//  MAX_LATENCY    15  largest loopback latency searched, in clk cycles
//  LOCK_COUNT     8   consecutive matches needed to lock
//  UNLOCK_ERRORS  4   consecutive mismatches that drop lock
//  ERR_CNT_WIDTH  16  width of both error counters
// PORTS
//  clk               in   1                         clock
//  rst               in   1                         async reset, active high
//  cfg_enable        in   1                         run generator and checker
//  cfg_hdr           in   HDR_WIDTH                 header sent with every pattern (reset use 2'b10)
//  cfg_pat_wr        in   1                         pattern table write strobe
//  cfg_pat_addr      in   $clog2(PATTERN_COUNT)     table write index
//  cfg_pat_data      in   DATA_WIDTH                table write data
//  clear_counters    in   1                         synchronous zero of both error counters
//  tx_data           out  DATA_WIDTH                generated block
//  tx_hdr            out  HDR_WIDTH                 generated header
//  tx_valid          out  1                         tx_data/tx_hdr valid
//  rx_data           in   DATA_WIDTH                looped-back block
//  rx_hdr            in   HDR_WIDTH                 looped-back header
//  rx_valid          in   1                         rx_data/rx_hdr valid
//  chk_lock          out  1                         checker locked
//  chk_latency       out  $clog2(MAX_LATENCY+1)     current candidate/locked latency
//  block_err_count   out  ERR_CNT_WIDTH             mismatched blocks while locked, saturating
//  bit_err_count     out  ERR_CNT_WIDTH             mismatched bits while locked, saturating
//  err_pulse         out  1                         one-cycle pulse per mismatched block while locked
// BEHAVIOUR
//  Reset: all outputs 0. Table entry i = byte {FF,00,55,AA,FE,07}[i mod 6] replicated DATA_WIDTH/8 times.
//  Generator: index idx resets to 0. While cfg_enable=1, each clk registers tx_data=table[idx], tx_hdr=cfg_hdr, tx_valid=1.
//   idx then advances, wrapping PATTERN_COUNT-1 -> 0. While cfg_enable=0, tx_valid=0 and idx holds.
//  Table write: when cfg_pat_wr=1, entry cfg_pat_addr is written. New data is sent from the next clk.
//   Addresses >= PATTERN_COUNT are ignored.
//  History: a shift register of MAX_LATENCY+1 idx values. hist[0] = idx currently on tx_data.
//   It shifts on every clk with tx_valid=1.
//  Expected block for latency L = {cfg_hdr, table[hist[L]]}. Compare is exact over header and data.
//  Compares happen only on cycles with rx_valid=1. With rx_valid=0 there is no state, counter or latency change.
//  FSM HUNT (reset state):
//   - match: match_cnt+1. On reaching LOCK_COUNT -> LOCK, and chk_lock=1 the next cycle.
//   - mismatch: match_cnt=0, L=L+1, wrapping MAX_LATENCY -> 0.
//  FSM LOCK:
//   - match: err_run=0.
//   - mismatch: err_pulse=1 (registered, next cycle), block_err_count+1, bit_err_count += popcount(rx^expected), err_run+1.
//   - err_run reaching UNLOCK_ERRORS: -> HUNT, chk_lock=0, match_cnt=0. L is kept, so it is retried first.
//  Counters advance only in LOCK. Both saturate at all-ones. A bit-count add that would overflow clamps to all-ones.
//  clear_counters has priority over a same-cycle increment; counters read 0 the next cycle.
//  cfg_enable=0: FSM forced to HUNT, L=0, match_cnt=err_run=0. Counters hold.
//  Periodic table: the locked latency is ambiguous modulo any repeat period. The smallest matching L is found.
//  Async rst mid-operation: all state and counters return to their reset values immediately.
// TESTING
//  1 Reset: rst=1 -> all outputs 0. After release with cfg_enable=1, tx_data sequence is FF..,00..,55..,AA..,FE..,07..,FF.. .
//  2 Loopback with a 7-cycle delay, rx_valid=1 -> chk_lock=1 with chk_latency=7. Error counts stay 0 over 1000 cycles.
//  3 While locked, flip 3 bits in one rx block -> block_err_count=1, bit_err_count=3, one err_pulse, chk_lock stays 1.
//  4 Corrupt 4 consecutive rx blocks -> chk_lock=0 after the 4th. Clean loopback then relocks at latency 7.
//  5 clear_counters asserted in the same cycle as a mismatch -> both counters read 0. Force 65535+ errors -> block_err_count holds 16'hFFFF.
//  6 Loopback delay 20 (> MAX_LATENCY) -> chk_lock never asserts and chk_latency cycles 0..15.
//    Rewrite entry 2 to a distinct value mid-run -> relock succeeds with the new pattern.

Source files
------------

// File: rtl/pcs_pattern_gen_chk_if.sv
// SERDES-side bus of the PCS pattern generator/checker: TX block out, looped-back RX block in.
interface pcs_pattern_gen_chk_if #(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic [HDR_WIDTH-1:0]  tx_hdr;
  logic                  tx_valid;
  logic [DATA_WIDTH-1:0] rx_data;
  logic [HDR_WIDTH-1:0]  rx_hdr;
  logic                  rx_valid;

  modport master (
    output tx_data, tx_hdr, tx_valid,
    input  rx_data, rx_hdr, rx_valid
  );

  modport slave (
    input  tx_data, tx_hdr, tx_valid,
    output rx_data, rx_hdr, rx_valid
  );
endinterface

// File: rtl/pcs_pattern_gen_chk.sv
// Fixed-pattern generator and loopback checker for 10GBASE-R PCS line-loopback testing.
// The checker hunts the loopback latency, locks, and counts block/bit errors while locked.
module pcs_pattern_gen_chk #(
  parameter int DATA_WIDTH    = 64,
  parameter int HDR_WIDTH     = 2,
  parameter int PATTERN_COUNT = 6,
  parameter int MAX_LATENCY   = 15,
  parameter int LOCK_COUNT    = 8,
  parameter int UNLOCK_ERRORS = 4,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cfg_enable,
  input  logic [HDR_WIDTH-1:0]               cfg_hdr,
  input  logic                               cfg_pat_wr,
  input  logic [$clog2(PATTERN_COUNT)-1:0]   cfg_pat_addr,
  input  logic [DATA_WIDTH-1:0]              cfg_pat_data,
  input  logic                               clear_counters,
  pcs_pattern_gen_chk_if.master              serdes,
  output logic                               chk_lock,
  output logic [$clog2(MAX_LATENCY+1)-1:0]   chk_latency,
  output logic [ERR_CNT_WIDTH-1:0]           block_err_count,
  output logic [ERR_CNT_WIDTH-1:0]           bit_err_count,
  output logic                               err_pulse
);
  localparam int AW = $clog2(PATTERN_COUNT);
  localparam int LW = $clog2(MAX_LATENCY + 1);
  localparam int BW = HDR_WIDTH + DATA_WIDTH;
  localparam int PW = $clog2(BW + 1);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int EW = $clog2(UNLOCK_ERRORS + 1);

  typedef enum logic {ST_HUNT, ST_LOCK} state_t;

  logic [DATA_WIDTH-1:0] pat_tab [PATTERN_COUNT];
  logic [AW-1:0]         idx;
  logic [AW-1:0]         hist [MAX_LATENCY+1];

  state_t              state, state_nxt;
  logic [LW-1:0]       lat, lat_nxt;
  logic [MW-1:0]       match_cnt, match_nxt;
  logic [EW-1:0]       err_run, err_run_nxt;
  logic                lock_err;
  logic [BW-1:0]       expected, diff;
  logic                mismatch;
  logic [PW-1:0]       diff_bits;
  logic [ERR_CNT_WIDTH:0] bit_sum;

  function automatic logic [DATA_WIDTH-1:0] default_entry(int unsigned i);
    logic [7:0] b;
    case (i % 6)
      0:       b = 8'hFF;
      1:       b = 8'h00;
      2:       b = 8'h55;
      3:       b = 8'hAA;
      4:       b = 8'hFE;
      default: b = 8'h07;
    endcase
    return {(DATA_WIDTH/8){b}};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < PATTERN_COUNT; i++) pat_tab[i] <= default_entry(i);
    end else if (cfg_pat_wr && (32'(cfg_pat_addr) < PATTERN_COUNT)) begin
      pat_tab[cfg_pat_addr] <= cfg_pat_data;
    end
  end

  // hist[k] is the table index that was on tx_data k generated blocks ago
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx             <= '0;
      serdes.tx_data  <= '0;
      serdes.tx_hdr   <= '0;
      serdes.tx_valid <= 1'b0;
      for (int unsigned i = 0; i <= MAX_LATENCY; i++) hist[i] <= '0;
    end else begin
      serdes.tx_valid <= cfg_enable;
      if (cfg_enable) begin
        serdes.tx_data <= pat_tab[idx];
        serdes.tx_hdr  <= cfg_hdr;
        idx            <= (idx == AW'(PATTERN_COUNT - 1)) ? '0 : idx + 1'b1;
        hist[0]        <= idx;
        for (int unsigned i = 1; i <= MAX_LATENCY; i++) hist[i] <= hist[i-1];
      end
    end
  end

  assign expected = {cfg_hdr, pat_tab[hist[lat]]};
  assign diff     = {serdes.rx_hdr, serdes.rx_data} ^ expected;
  assign mismatch = |diff;

  always_comb begin
    diff_bits = '0;
    for (int unsigned i = 0; i < BW; i++) diff_bits = diff_bits + PW'(diff[i]);
  end

  always_comb begin
    state_nxt   = state;
    lat_nxt     = lat;
    match_nxt   = match_cnt;
    err_run_nxt = err_run;
    lock_err    = 1'b0;
    if (!cfg_enable) begin
      state_nxt   = ST_HUNT;
      lat_nxt     = '0;
      match_nxt   = '0;
      err_run_nxt = '0;
    end else if (serdes.rx_valid) begin
      case (state)
        ST_HUNT: begin
          if (mismatch) begin
            match_nxt = '0;
            lat_nxt   = (lat == LW'(MAX_LATENCY)) ? '0 : lat + 1'b1;
          end else begin
            match_nxt = match_cnt + 1'b1;
            if (match_nxt == MW'(LOCK_COUNT)) begin
              state_nxt = ST_LOCK;
              match_nxt = '0;
            end
          end
        end
        ST_LOCK: begin
          if (mismatch) begin
            lock_err    = 1'b1;
            err_run_nxt = err_run + 1'b1;
            // latency is kept on unlock so the hunt retries it first
            if (err_run_nxt == EW'(UNLOCK_ERRORS)) begin
              state_nxt   = ST_HUNT;
              err_run_nxt = '0;
              match_nxt   = '0;
            end
          end else begin
            err_run_nxt = '0;
          end
        end
        default: state_nxt = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_HUNT;
      lat       <= '0;
      match_cnt <= '0;
      err_run   <= '0;
    end else begin
      state     <= state_nxt;
      lat       <= lat_nxt;
      match_cnt <= match_nxt;
      err_run   <= err_run_nxt;
    end
  end

  assign chk_lock    = (state == ST_LOCK);
  assign chk_latency = lat;
  assign bit_sum     = {1'b0, bit_err_count} + (ERR_CNT_WIDTH+1)'(diff_bits);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      block_err_count <= '0;
      bit_err_count   <= '0;
      err_pulse       <= 1'b0;
    end else begin
      err_pulse <= lock_err;
      if (clear_counters) begin
        block_err_count <= '0;
        bit_err_count   <= '0;
      end else if (lock_err) begin
        if (block_err_count != '1) block_err_count <= block_err_count + 1'b1;
        bit_err_count <= bit_sum[ERR_CNT_WIDTH] ? '1 : bit_sum[ERR_CNT_WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_pcs_pattern_gen_chk.sv
// Bench for pcs_pattern_gen_chk: bench-side loopback delay line, TX scoreboard, table-driven error phases.
module tb_pcs_pattern_gen_chk;
  localparam int DW    = 64;
  localparam int HW    = 2;
  localparam int PC    = 24;
  localparam int ERR_W = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_enable;
  logic [HW-1:0] cfg_hdr;
  logic          cfg_pat_wr;
  logic [4:0]    cfg_pat_addr;
  logic [DW-1:0] cfg_pat_data;
  logic          clear_counters;
  logic          chk_lock;
  logic [3:0]    chk_latency;
  logic [ERR_W-1:0] block_err_count;
  logic [ERR_W-1:0] bit_err_count;
  logic          err_pulse;

  pcs_pattern_gen_chk_if #(.DATA_WIDTH(DW), .HDR_WIDTH(HW)) sif ();

  pcs_pattern_gen_chk #(
    .DATA_WIDTH(DW), .HDR_WIDTH(HW), .PATTERN_COUNT(PC), .MAX_LATENCY(15),
    .LOCK_COUNT(8), .UNLOCK_ERRORS(4), .ERR_CNT_WIDTH(ERR_W)
  ) dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_hdr(cfg_hdr),
    .cfg_pat_wr(cfg_pat_wr), .cfg_pat_addr(cfg_pat_addr), .cfg_pat_data(cfg_pat_data),
    .clear_counters(clear_counters), .serdes(sif), .chk_lock(chk_lock),
    .chk_latency(chk_latency), .block_err_count(block_err_count),
    .bit_err_count(bit_err_count), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          valid;
    logic [HW-1:0] hdr;
    logic [DW-1:0] data;
  } tx_exp_t;

  typedef struct {
    int   n_bad;
    int   nbits;
    int   cycles;
    logic exp_mid_lock;
    logic exp_lock;
    int   exp_lat;
    int   exp_blk;
    int   exp_bit;
  } vec_t;

  tx_exp_t     sb [$];
  logic [DW-1:0] m_tab [PC];
  int unsigned m_idx;
  logic [7:0]  defb [6] = '{8'hFF, 8'h00, 8'h55, 8'hAA, 8'hFE, 8'h07};
  logic [66:0] bh [32];
  int          delay;
  logic        lb_on;
  logic [65:0] flip_next;
  int          pulse_cnt;
  int          n_vec = 0;
  int          n_err = 0;
  vec_t        vt [4];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [65:0] low_mask(int n);
    logic [65:0] m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    m_idx = 0;
    for (int i = 0; i < PC; i++) m_tab[i] = {8{defb[i % 6]}};
    for (int k = 0; k < 32; k++) bh[k] = '0;
    sb.delete();
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_tx_data"}, sif.tx_data, 0);
    check({tag, "_tx_hdr"}, 64'(sif.tx_hdr), 0);
    check({tag, "_tx_valid"}, 64'(sif.tx_valid), 0);
    check({tag, "_lock"}, 64'(chk_lock), 0);
    check({tag, "_latency"}, 64'(chk_latency), 0);
    check({tag, "_blk"}, 64'(block_err_count), 0);
    check({tag, "_bit"}, 64'(bit_err_count), 0);
    check({tag, "_pulse"}, 64'(err_pulse), 0);
  endtask

  // One clock: push the expected TX block, step, pop/compare, then drive the looped-back RX.
  task automatic tick();
    tx_exp_t e;
    e.valid = cfg_enable;
    e.hdr   = cfg_hdr;
    e.data  = m_tab[m_idx];
    if (cfg_enable) m_idx = (m_idx == PC - 1) ? 0 : m_idx + 1;
    sb.push_back(e);
    if (cfg_pat_wr && cfg_pat_addr < PC) m_tab[cfg_pat_addr] = cfg_pat_data;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("tx_valid", 64'(sif.tx_valid), 64'(e.valid));
    if (e.valid) begin
      check("tx_data", sif.tx_data, e.data);
      check("tx_hdr", 64'(sif.tx_hdr), 64'(e.hdr));
    end
    if (err_pulse) pulse_cnt++;
    for (int k = 31; k > 0; k--) bh[k] = bh[k-1];
    bh[0] = {sif.tx_valid, sif.tx_hdr, sif.tx_data};
    {sif.rx_hdr, sif.rx_data} = bh[delay][65:0] ^ flip_next;
    sif.rx_valid = lb_on & bh[delay][66];
    flip_next = '0;
  endtask

  task automatic wait_lock(string name, int exp_lat);
    int w = 0;
    while (!chk_lock && w < 300) begin
      tick();
      w++;
    end
    check({name, "_lock"}, 64'(chk_lock), 1);
    check({name, "_latency"}, 64'(chk_latency), 64'(exp_lat));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   p0;
    int   seen;
    int   lock_seen;
    logic [3:0] prev_lat;
    logic [7:0] b;

    vt[0] = '{0, 0, 1000, 1'b1, 1'b1, 7, 0, 0};
    vt[1] = '{1, 3, 20,   1'b1, 1'b1, 7, 1, 3};
    vt[2] = '{3, 2, 20,   1'b1, 1'b1, 7, 4, 9};
    vt[3] = '{4, 1, 30,   1'b0, 1'b1, 7, 8, 13};

    rst = 1'b1; cfg_enable = 1'b0; cfg_hdr = 2'b10; cfg_pat_wr = 1'b0;
    cfg_pat_addr = '0; cfg_pat_data = '0; clear_counters = 1'b0;
    sif.rx_data = '0; sif.rx_hdr = '0; sif.rx_valid = 1'b0;
    lb_on = 1'b0; delay = 0; flip_next = '0; pulse_cnt = 0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");

    // generator sequence from the default table
    @(negedge clk);
    rst = 1'b0;
    cfg_enable = 1'b1;
    repeat (13) tick();

    // distinct table contents so the loopback latency is unambiguous
    for (int i = 0; i < PC; i++) begin
      b = 8'(i);
      cfg_pat_wr = 1'b1; cfg_pat_addr = 5'(i);
      cfg_pat_data = 64'hA5C3_0F96_3C5A_E187 ^ {8{b}};
      tick();
    end
    cfg_pat_addr = 5'd26; cfg_pat_data = '1;
    tick();
    cfg_pat_wr = 1'b0;
    repeat (PC + 2) tick();

    delay = 7; lb_on = 1'b1;
    wait_lock("acquire7", 7);

    for (int v = 0; v < 4; v++) begin
      p0 = pulse_cnt;
      for (int j = 0; j < vt[v].n_bad; j++) begin
        flip_next = low_mask(vt[v].nbits);
        tick();
      end
      tick();
      check("vec_mid_lock", 64'(chk_lock), 64'(vt[v].exp_mid_lock));
      repeat (vt[v].cycles) tick();
      check("vec_lock", 64'(chk_lock), 64'(vt[v].exp_lock));
      check("vec_latency", 64'(chk_latency), 64'(vt[v].exp_lat));
      check("vec_blk", 64'(block_err_count), 64'(vt[v].exp_blk));
      check("vec_bit", 64'(bit_err_count), 64'(vt[v].exp_bit));
      check("vec_pulses", 64'(pulse_cnt - p0), 64'(vt[v].n_bad));
    end

    // clear in the same cycle as a counted mismatch
    flip_next = low_mask(5);
    tick();
    clear_counters = 1'b1;
    tick();
    clear_counters = 1'b0;
    check("clr_blk", 64'(block_err_count), 0);
    check("clr_bit", 64'(bit_err_count), 0);
    check("clr_pulse", 64'(err_pulse), 1);
    check("clr_lock", 64'(chk_lock), 1);
    flip_next = low_mask(2);
    tick();
    tick();
    check("after_clr_blk", 64'(block_err_count), 1);
    check("after_clr_bit", 64'(bit_err_count), 2);

    // saturation: runs of 3 fully corrupted blocks keep lock
    repeat (1400) begin
      repeat (3) begin
        flip_next = '1;
        tick();
      end
      tick();
    end
    tick();
    check("sat_lock", 64'(chk_lock), 1);
    check("sat_blk", 64'(block_err_count), 64'(12'hFFF));
    check("sat_bit", 64'(bit_err_count), 64'(12'hFFF));
    clear_counters = 1'b1;
    tick();
    clear_counters = 1'b0;
    check("sat_clr_blk", 64'(block_err_count), 0);
    check("sat_clr_bit", 64'(bit_err_count), 0);

    // loopback delay beyond the search range
    delay = 20;
    repeat (10) tick();
    seen = 0; lock_seen = 0;
    prev_lat = chk_latency;
    repeat (400) begin
      tick();
      check("hunt_step", 64'(chk_latency), 64'(4'(prev_lat + 4'd1)));
      prev_lat = chk_latency;
      seen = seen | (1 << chk_latency);
      if (chk_lock) lock_seen++;
    end
    check("far_no_lock", 64'(lock_seen), 0);
    check("far_lat_sweep", 64'(seen), 64'(16'hFFFF));

    // rewrite entry 2 and restore the 7-cycle loop
    cfg_pat_wr = 1'b1; cfg_pat_addr = 5'd2; cfg_pat_data = 64'hDEAD_BEEF_0BAD_F00D;
    tick();
    cfg_pat_wr = 1'b0;
    delay = 7;
    wait_lock("relock_newpat", 7);
    clear_counters = 1'b1;
    tick();
    clear_counters = 1'b0;
    repeat (100) tick();
    check("newpat_blk", 64'(block_err_count), 0);
    check("newpat_lock", 64'(chk_lock), 1);
    flip_next = low_mask(1);
    tick();
    tick();
    check("pre_rst_blk", 64'(block_err_count), 1);

    // cfg_enable low: generator stalls, checker returns to hunt at latency 0
    cfg_enable = 1'b0;
    repeat (3) tick();
    check("dis_lock", 64'(chk_lock), 0);
    check("dis_latency", 64'(chk_latency), 0);
    check("dis_blk_hold", 64'(block_err_count), 1);
    cfg_enable = 1'b1;
    repeat (4) tick();

    // asynchronous reset mid-cycle
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    lb_on = 1'b0; delay = 0;
    sif.rx_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (7) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
